// File: rtl/led_cube_pkg.sv
// Shared types and defaults for the LED cube plane scan logic.
package led_cube_pkg;

    localparam int DEF_PLANES    = 8;
    localparam int DEF_PS_WIDTH  = 4;
    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW,
        ST_GUARD
    } scan_state_t;

    // Width of a plane index; a single-plane cube still needs one bit.
    function automatic int idx_width(input int planes);
        return (planes > 1) ? $clog2(planes) : 1;
    endfunction

endpackage

// File: rtl/prsc_tick.sv
// Power-of-two scan-tick prescaler: tick fires whenever the low divSel bits of
// the free-running counter are all ones.
module prsc_tick
    import led_cube_pkg::*;
#(
    parameter int PS_WIDTH  = DEF_PS_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                clkIn,
    input  logic                reset,
    input  logic                enable,
    input  logic [PS_WIDTH-1:0] divSel,
    output logic                tick
);

    localparam int SEL_W   = idx_width(CNT_WIDTH);
    localparam int MAX_SEL = CNT_WIDTH - 1;

    logic [CNT_WIDTH-1:0] ps_cnt_reg;
    logic [CNT_WIDTH-1:0] ps_cnt_next;
    logic [CNT_WIDTH-1:0] mask;
    logic [SEL_W-1:0]     sel_eff;

    // Selects wider than the counter would never tick, so clamp them.
    always_comb begin
        sel_eff = SEL_W'(MAX_SEL);
        if (int'(divSel) <= MAX_SEL) begin
            sel_eff = SEL_W'(divSel);
        end
    end

    generate
        for (genvar gi = 0; gi < CNT_WIDTH; gi++) begin : g_mask
            assign mask[gi] = (int'(sel_eff) > gi);
        end
    endgenerate

    always_comb begin
        ps_cnt_next = '0;
        if (enable) begin
            ps_cnt_next = ps_cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            ps_cnt_reg <= '0;
        end else begin
            ps_cnt_reg <= ps_cnt_next;
        end
    end

    assign tick = ((ps_cnt_reg & mask) == mask);

endmodule

// File: rtl/led_plane_scheduler.sv
// LED cube plane scan sequencer: loads each plane over req/ack, shows it for a
// programmable number of prescaled ticks, then blanks for one guard cycle.
module led_plane_scheduler
    import led_cube_pkg::*;
#(
    parameter int PLANES    = DEF_PLANES,
    parameter int PS_WIDTH  = DEF_PS_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int IDX_W    = idx_width(PLANES)
) (
    input  logic                 clkIn,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PS_WIDTH-1:0]  divSel,
    input  logic [CNT_WIDTH-1:0] dwell,
    output logic                 loadReq,
    input  logic                 loadAck,
    output logic [IDX_W-1:0]     planeIdx,
    output logic [PLANES-1:0]    planeSel,
    output logic                 blank,
    output logic                 frameStart,
    output logic                 busy
);

    scan_state_t          state_reg;
    logic [IDX_W-1:0]     plane_idx_reg;
    logic [CNT_WIDTH-1:0] dwell_cnt_reg;
    logic                 load_req_reg;
    logic [PLANES-1:0]    plane_sel_reg;
    logic                 blank_reg;
    logic                 frame_start_reg;
    logic                 busy_reg;

    logic                 tick;
    logic [IDX_W-1:0]     idx_inc;
    logic [PLANES-1:0]    idx_onehot;
    logic [CNT_WIDTH-1:0] dwell_load;

    prsc_tick #(
        .PS_WIDTH  (PS_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_prsc_tick (
        .clkIn  (clkIn),
        .reset  (reset),
        .enable (enable),
        .divSel (divSel),
        .tick   (tick)
    );

    generate
        for (genvar gi = 0; gi < PLANES; gi++) begin : g_onehot
            assign idx_onehot[gi] = (plane_idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign idx_inc    = (plane_idx_reg == IDX_W'(PLANES - 1)) ? '0
                                                              : plane_idx_reg + IDX_W'(1);
    assign dwell_load = (dwell == '0) ? CNT_WIDTH'(1) : dwell;

    // Outputs are set alongside the state they belong to so every port is a flop.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            plane_idx_reg   <= '0;
            dwell_cnt_reg   <= '0;
            load_req_reg    <= 1'b0;
            plane_sel_reg   <= '0;
            blank_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_reg       <= ST_LOAD;
                        plane_idx_reg   <= '0;
                        load_req_reg    <= 1'b1;
                        busy_reg        <= 1'b1;
                        frame_start_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // The request stays up until acked, even once enable has dropped.
                    if (loadAck) begin
                        load_req_reg <= 1'b0;
                        if (enable) begin
                            state_reg     <= ST_SHOW;
                            dwell_cnt_reg <= dwell_load;
                            blank_reg     <= 1'b0;
                            plane_sel_reg <= idx_onehot;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                ST_SHOW: begin
                    if (!enable) begin
                        state_reg     <= ST_IDLE;
                        blank_reg     <= 1'b1;
                        plane_sel_reg <= '0;
                        busy_reg      <= 1'b0;
                    end else if (tick) begin
                        if (dwell_cnt_reg == CNT_WIDTH'(1)) begin
                            state_reg     <= ST_GUARD;
                            blank_reg     <= 1'b1;
                            plane_sel_reg <= '0;
                        end else begin
                            dwell_cnt_reg <= dwell_cnt_reg - CNT_WIDTH'(1);
                        end
                    end
                end
                ST_GUARD: begin
                    if (!enable) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg       <= ST_LOAD;
                        plane_idx_reg   <= idx_inc;
                        load_req_reg    <= 1'b1;
                        frame_start_reg <= (idx_inc == '0);
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    load_req_reg  <= 1'b0;
                    plane_sel_reg <= '0;
                    blank_reg     <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign loadReq    = load_req_reg;
    assign planeIdx   = plane_idx_reg;
    assign planeSel   = plane_sel_reg;
    assign blank      = blank_reg;
    assign frameStart = frame_start_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_led_plane_scheduler.sv
// Bench for led_plane_scheduler: each scan run is predicted as a cycle timeline
// built from plane schedule arithmetic, then compared cycle by cycle.
module tb_led_plane_scheduler;

    localparam int PLANES = 8;
    localparam int PS_W   = 4;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 3;

    logic              clkIn = 1'b0;
    logic              reset;
    logic              enable;
    logic [PS_W-1:0]   divSel;
    logic [CNT_W-1:0]  dwell;
    logic              loadReq;
    logic              loadAck;
    logic [IDX_W-1:0]  planeIdx;
    logic [PLANES-1:0] planeSel;
    logic              blank;
    logic              frameStart;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int ack_dly  = 0;
    int req_age  = 0;

    logic [14:0] exp_q[$];

    led_plane_scheduler #(
        .PLANES    (PLANES),
        .PS_WIDTH  (PS_W),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clkIn      (clkIn),
        .reset      (reset),
        .enable     (enable),
        .divSel     (divSel),
        .dwell      (dwell),
        .loadReq    (loadReq),
        .loadAck    (loadAck),
        .planeIdx   (planeIdx),
        .planeSel   (planeSel),
        .blank      (blank),
        .frameStart (frameStart),
        .busy       (busy)
    );

    always #5 clkIn = ~clkIn;

    // Loader model: acks once the request has been pending ack_dly cycles.
    always @(posedge clkIn) begin
        if (reset || !loadReq) req_age <= 0;
        else                   req_age <= req_age + 1;
    end
    assign loadAck = loadReq && (req_age >= ack_dly);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [14:0] mk(input bit req, input bit blk, input int sel,
                                       input int idx, input bit fs, input bit bsy);
        logic [7:0] s8;
        logic [2:0] i3;
        s8 = 8'(sel);
        i3 = 3'(idx);
        return {req, blk, s8, i3, fs, bsy};
    endfunction

    function automatic logic [14:0] observed();
        return {loadReq, blank, planeSel, planeIdx, frameStart, busy};
    endfunction

    // Cycle j counts from the first LOAD cycle; the prescaler then holds j+1.
    // Enable is seen low at the end of cycle n_on-1.
    task automatic build_expect(input int sel, input int dw, input int k, input int n_on);
        int j = 0;
        int p = 0;
        int dd;
        int per;
        int ticks;
        bit stop = 0;
        bit shown;
        exp_q.delete();
        dd  = (dw == 0) ? 1 : dw;
        per = 1 << ((sel > CNT_W - 1) ? CNT_W - 1 : sel);
        while (!stop) begin
            for (int i = 0; i <= k; i++) begin
                exp_q.push_back(mk(1, 1, 0, p, (i == 0 && p == 0), 1));
                j++;
            end
            if (j - 1 >= n_on - 1) break;
            ticks = 0;
            shown = 0;
            while (!shown && !stop) begin
                exp_q.push_back(mk(0, 0, 1 << p, p, 0, 1));
                if (j == n_on - 1) stop = 1;
                else if (((j + 1) % per) == per - 1) begin
                    ticks++;
                    if (ticks == dd) shown = 1;
                end
                j++;
            end
            if (stop) break;
            exp_q.push_back(mk(0, 1, 0, p, 0, 1));
            if (j == n_on - 1) break;
            j++;
            p = (p + 1) % PLANES;
        end
        repeat (4) exp_q.push_back(mk(0, 1, 0, p, 0, 0));
    endtask

    task automatic run_scan(input string tag, input int sel, input int dw, input int k, input int n_on);
        build_expect(sel, dw, k, n_on);
        @(negedge clkIn);
        divSel  = PS_W'(sel);
        dwell   = CNT_W'(dw);
        ack_dly = k;
        enable  = 1'b1;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(posedge clkIn);
            #1;
            check_val(tag, 32'(observed()), 32'(exp_q[j]));
            if (j == n_on - 1) enable = 1'b0;
        end
        $display("run %s divSel=%0d dwell=%0d ack=%0d on=%0d cycles=%0d errors=%0d",
                 tag, sel, dw, k, n_on, exp_q.size(), n_errors);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        reset  = 1'b1;
        enable = 1'b0;
        divSel = '0;
        dwell  = '0;
        repeat (2) @(posedge clkIn);
        #1;
        check_val("reset_vals", 32'(observed()), 32'(mk(0, 1, 0, 0, 0, 0)));
        @(negedge clkIn);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clkIn);
            #1;
            check_val("idle_hold", 32'(observed()), 32'(mk(0, 1, 0, 0, 0, 0)));
        end
        $display("idle hold checked 20 cycles errors=%0d", n_errors);

        run_scan("basic", 0, 3, 0, 85);
        run_scan("prescale2", 2, 2, 0, 60);
        run_scan("slow_ack", 1, 0, 5, 40);
        run_scan("dis_load", 0, 3, 3, 1);
        run_scan("dis_show", 0, 4, 0, 3);
        run_scan("dis_final_tick", 0, 3, 0, 4);
        run_scan("dis_guard", 0, 3, 0, 5);
        run_scan("div15", 15, 1, 0, 32800);

        for (int r = 0; r < 12; r++) begin
            run_scan("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), int'($urandom_range(5, 120)));
        end

        // Reset while plane 5 is displayed, then restart from plane 0.
        @(negedge clkIn);
        divSel  = '0;
        dwell   = CNT_W'(3);
        ack_dly = 0;
        enable  = 1'b1;
        waited  = 0;
        while (!(planeIdx == 3'd5 && !blank) && waited < 200) begin
            @(posedge clkIn);
            #1;
            waited++;
        end
        if (waited >= 200) check_val("wait_plane5", 32'(0), 32'(1));
        @(negedge clkIn);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clkIn);
        #1;
        check_val("reset_mid_show", 32'(observed()), 32'(mk(0, 1, 0, 0, 0, 0)));
        @(negedge clkIn);
        reset = 1'b0;
        $display("reset mid-show waited=%0d errors=%0d", waited, n_errors);
        run_scan("restart", 0, 3, 0, 50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_plane_scheduler.md
# led_plane_scheduler

Sequences the LED cube's plane multiplexing: derives a scan tick from `clkIn` with a programmable power-of-two prescaler, requests each plane's column data from the shift loader over a req/ack handshake, then enables that plane for a programmable dwell before blanking and moving on. It sits between the global clock/reset and the plane driver, and replaces free-running prescaler use with a controlled scan schedule.

## Interface
- `PLANES`, 8: number of cube planes; must be ≥2.
- `PS_WIDTH`, 4: width of prescaler select.
- `CNT_WIDTH`, 16: width of dwell and prescaler counters.
- `clkIn` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: run the scan when high.
- `divSel` input PS_WIDTH: tick period is 2^divSel clocks. Values above CNT_WIDTH−1 saturate to CNT_WIDTH−1.
- `dwell` input CNT_WIDTH: ticks per plane. 0 is treated as 1.
- `loadReq` output 1: request for data for plane `planeIdx`.
- `loadAck` input 1: loader has latched the plane data.
- `planeIdx` output $clog2(PLANES): plane being loaded or shown.
- `planeSel` output PLANES: one-hot plane enable; all zero when blanked.
- `blank` output 1: columns must be off.
- `frameStart` output 1: one-cycle pulse at the start of plane 0's LOAD.
- `busy` output 1: FSM not in IDLE.

## Operation
- **Prescaler:**
  - Free-running `psCnt` (CNT_WIDTH) increments every cycle while `enable` is high and clears while it is low.
  - `tick` = (`psCnt` & mask) == mask, where mask = 2^divSel − 1. With `divSel`=0, `tick` fires every cycle.
  - A change to `divSel` takes effect immediately; `psCnt` is not cleared.
- **FSM states:** IDLE, LOAD, SHOW, GUARD.
- **IDLE:** `blank`=1, `planeSel`=0, `loadReq`=0. When `enable`=1: `planeIdx`←0, go to LOAD, assert `frameStart`.
- **LOAD:** `loadReq`=1, `blank`=1. When `loadAck`=1:
  - if `enable`=1: go to SHOW and set `dwellCnt` ← max(`dwell`,1);
  - otherwise go to IDLE.
  - An outstanding request is never withdrawn before ack.
- **SHOW:** `blank`=0, `planeSel`=one-hot(`planeIdx`).
  - Each `tick` decrements `dwellCnt`.
  - A `tick` with `dwellCnt`==1 moves to GUARD.
  - `enable`=0 moves to IDLE on the next edge.
- **GUARD:** exactly one cycle with `blank`=1 and `planeSel`=0 (anti-ghosting).
  - Then `planeIdx`←`planeIdx`+1, wrapping PLANES−1→0, and go to LOAD.
  - A wrap to 0 asserts `frameStart` on LOAD entry.
  - If `enable`=0, go to IDLE instead.
- **Sampling:** `dwell` is sampled only on the LOAD→SHOW transition; changes during SHOW affect the next plane.
- **Ack outside LOAD:** `loadAck` is ignored.
- **Simultaneous events:** if `enable` falls in the same cycle as the final dwell tick, the next state is IDLE.
- **Reset mid-operation:** the next edge forces IDLE and clears all counters; `loadReq` drops even if unacknowledged, and the loader must tolerate this.

## Timing
- **Reset values:** `loadReq`=0, `planeIdx`=0, `planeSel`=0, `blank`=1, `frameStart`=0, `busy`=0, `psCnt`=0.
- **All outputs are registered.** A state change at edge N is visible after edge N.
- **Start-up:**
  - `enable` sampled high at edge N: LOAD, `loadReq` and `frameStart` high after edge N.
  - `loadAck` high in the cycle after edge N+k: SHOW after edge N+k+1, and `loadReq` is low after that same edge.
- **Plane period:**
  - SHOW lasts `dwell` ticks (ending on the clock of the `dwell`-th tick), plus 1 GUARD cycle, plus LOAD time (≥1 cycle).
  - With `divSel`=0, `dwell`=D and ack returned combinationally in the first LOAD cycle: period = D+2 cycles.
- **`frameStart`:** exactly one cycle wide, once per frame.

## Structure
- **Package `led_cube_pkg`:**
  - FSM state enum (IDLE, LOAD, SHOW, GUARD);
  - default PLANES, PS_WIDTH and CNT_WIDTH constants;
  - plane-index width function.
- **Sub-module `prsc_tick`:** contains `psCnt`, the mask generation and `divSel` saturation; ports `clkIn`, `reset`, `enable`, `divSel`, `tick`.
- **Top level:** FSM, `dwellCnt`, `planeIdx` counter and the one-hot decode.

## Test plan
- **Reset/idle:** `reset` high 2 cycles, `enable`=0 → `blank`=1, `planeSel`=0, `loadReq`=0, `busy`=0 held for 20 cycles.
- **Basic scan:** `divSel`=0, `dwell`=3, ack tied to `loadReq` → `planeSel` follows 0x01, 0x02 … 0x80, 0x01. Each plane is shown 3 cycles, `blank`=1 for 2 cycles between planes, `frameStart` pulses every 40 cycles.
- **Prescaler:** `divSel`=2, `dwell`=2 → each SHOW lasts 8 cycles (±3 depending on phase). `divSel`=15 with CNT_WIDTH=16 gives a tick every 32768 cycles; `divSel` values above CNT_WIDTH−1 saturate.
- **Slow ack:** ack 5 cycles after `loadReq` → `loadReq` is held 5 cycles and `blank` stays 1. `dwell`=0 → SHOW lasts 1 tick.
- **Disable mid-LOAD:** drop `enable` while `loadReq` is high, ack 3 cycles later → `loadReq` stays high until ack, then IDLE, and SHOW is never entered.
- **Reset mid-SHOW:** plane 5 shown, `reset` pulsed → IDLE after the next edge with `planeIdx`=0. Re-enabling restarts at plane 0 with a `frameStart` pulse.
